// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic-array output path: default geometry,
// the row type and a counter-width helper.
package systolic_pkg;

    localparam int DEFAULT_MATRIX_SIZE = 2;
    localparam int DEFAULT_DATA_SIZE   = 32;

    typedef logic [DEFAULT_MATRIX_SIZE-1:0][DEFAULT_DATA_SIZE-1:0] row_t;

    // Width of a counter over n values, never narrower than one bit.
    function automatic int min1_clog2(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/output_deskewer_if.sv
// Skewed-input / aligned-output bundle of the output deskewer.
// master drives the skewed rows and the consumer ready; slave is the deskewer.
interface output_deskewer_if #(
    parameter int MATRIX_SIZE = systolic_pkg::DEFAULT_MATRIX_SIZE,
    parameter int DATA_SIZE   = systolic_pkg::DEFAULT_DATA_SIZE
) ();

    logic                                  enable_in;
    logic                                  in_valid;
    logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0] data_skewed;
    logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0] data;
    logic                                  out_valid;
    logic                                  out_ready;
    logic                                  out_last;
    logic                                  overflow;

    modport master (
        output enable_in, in_valid, data_skewed, out_ready,
        input  data, out_valid, out_last, overflow
    );

    modport slave (
        input  enable_in, in_valid, data_skewed, out_ready,
        output data, out_valid, out_last, overflow
    );

endinterface

// File: rtl/deskew_fifo.sv
// Aligned-row FIFO whose head entry is mirrored in an output register, so the
// consumer sees registered data/valid; accepts a push when full if a pop coincides.
module deskew_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic             rvalid,
    output logic [WIDTH-1:0] rdata
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
    logic [AW-1:0]               wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]               rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]               count_q, count_d;
    logic [WIDTH-1:0]            rdata_q, rdata_d;
    logic                        rvalid_q, rvalid_d;
    logic                        push_ok, pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    // The head register is reloaded from the post-write image so a row pushed
    // into an emptying FIFO appears on the very next cycle.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + 1'b1;
            count_d         = count_d + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            count_d  = count_d - 1'b1;
        end
        rvalid_d = (count_d != '0);
        rdata_d  = rvalid_d ? mem_d[rd_ptr_d] : rdata_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rvalid = rvalid_q;
    assign rdata  = rdata_q;

endmodule

// File: rtl/shift_reg.sv
// Enable-gated shift register of DEPTH stages (DEPTH >= 1) with synchronous
// active-low clear; all stages hold while en is low.
module shift_reg #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [DEPTH-1:0][WIDTH-1:0] stage_q, stage_d;

    always_comb begin
        stage_d = stage_q;
        if (en) begin
            stage_d[0] = din;
            for (int k = 1; k < DEPTH; k++) begin
                stage_d[k] = stage_q[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/output_deskewer.sv
// Realigns the staggered edge outputs of a systolic array into whole rows,
// buffers them and tags the last row of each matrix.
module output_deskewer
    import systolic_pkg::*;
#(
    parameter int MATRIX_SIZE = DEFAULT_MATRIX_SIZE,
    parameter int DATA_SIZE   = DEFAULT_DATA_SIZE,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic               clk,
    input  logic               reset,
    output_deskewer_if.slave   bus
);

    localparam int RW    = min1_clog2(MATRIX_SIZE);
    localparam int ROW_W = MATRIX_SIZE * DATA_SIZE;

    logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0] aligned;
    logic                                  vld_aligned;
    logic                                  push, pop;
    logic                                  fifo_full, fifo_empty, fifo_rvalid;
    logic [ROW_W-1:0]                      fifo_rdata;
    logic [RW-1:0]                         row_q, row_d;
    logic                                  overflow_q, overflow_d;

    // Lane i arrives i cycles late, so it waits MATRIX_SIZE-1-i cycles to
    // line up with the last lane, which passes straight through.
    for (genvar i = 0; i < MATRIX_SIZE; i++) begin : g_lane
        if (MATRIX_SIZE - 1 - i == 0) begin : g_wire
            assign aligned[i] = bus.data_skewed[i];
        end else begin : g_dly
            shift_reg #(
                .WIDTH (DATA_SIZE),
                .DEPTH (MATRIX_SIZE - 1 - i)
            ) u_dly (
                .clk   (clk),
                .reset (reset),
                .en    (bus.enable_in),
                .din   (bus.data_skewed[i]),
                .dout  (aligned[i])
            );
        end
    end

    if (MATRIX_SIZE == 1) begin : g_vld_wire
        assign vld_aligned = bus.in_valid;
    end else begin : g_vld_dly
        shift_reg #(
            .WIDTH (1),
            .DEPTH (MATRIX_SIZE - 1)
        ) u_vld (
            .clk   (clk),
            .reset (reset),
            .en    (bus.enable_in),
            .din   (bus.in_valid),
            .dout  (vld_aligned)
        );
    end

    assign push = bus.enable_in & vld_aligned;
    assign pop  = ~fifo_empty & bus.out_ready;

    deskew_fifo #(
        .WIDTH (ROW_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .push   (push),
        .wdata  (aligned),
        .pop    (pop),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .rvalid (fifo_rvalid),
        .rdata  (fifo_rdata)
    );

    always_comb begin
        row_d = row_q;
        if (pop) begin
            row_d = (row_q == RW'(MATRIX_SIZE - 1)) ? '0 : row_q + 1'b1;
        end
        overflow_d = overflow_q | (push & fifo_full & ~pop);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            row_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            row_q      <= row_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.data      = fifo_rdata;
    assign bus.out_valid = fifo_rvalid;
    assign bus.out_last  = fifo_rvalid & (row_q == RW'(MATRIX_SIZE - 1));
    assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_output_deskewer.sv
// Scenario bench for output_deskewer: skewed rows are driven cycle by cycle and
// every presented row is checked against a queue of expected aligned rows.
module tb_output_deskewer;
    import systolic_pkg::*;

    localparam int M  = 2;
    localparam int D  = 32;
    localparam int FD = 4;

    logic clk;
    logic reset;

    output_deskewer_if #(.MATRIX_SIZE(M), .DATA_SIZE(D)) bus ();

    output_deskewer #(
        .MATRIX_SIZE (M),
        .DATA_SIZE   (D),
        .FIFO_DEPTH  (FD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int         checks = 0;
    int         errors = 0;
    row_t       exp_q[$];
    int         exp_row = 0;
    logic [D-1:0] pend_l1 = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock of stimulus: lane 0 carries the new row, lane 1 the second
    // word of the row sampled in the previous enabled cycle.
    task automatic cycle(input bit en, input bit send, input logic [D-1:0] a,
                         input logic [D-1:0] b, input bit rdy);
        row_t r;
        bus.enable_in      = en;
        bus.in_valid       = send;
        bus.data_skewed[0] = send ? a : D'($urandom);
        bus.data_skewed[1] = pend_l1;
        bus.out_ready      = rdy;
        if (en) begin
            if (send) begin
                r = {b, a};
                exp_q.push_back(r);
            end
            pend_l1 = send ? b : D'($urandom);
        end
        @(negedge clk);
        if (bus.out_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got row %h, required no row", bus.data);
            end else begin
                checks++;
                if (bus.data !== exp_q[0]) begin
                    errors++;
                    $display("FAIL sb_data: got %h, required %h", bus.data, exp_q[0]);
                end
                checks++;
                if (bus.out_last !== 1'(exp_row == M - 1)) begin
                    errors++;
                    $display("FAIL sb_last: got %b, required %b", bus.out_last, (exp_row == M - 1));
                end
                if (rdy) begin
                    exp_q.delete(0);
                    exp_row = (exp_row + 1) % M;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        cycle(0, 0, '0, '0, 0);
        reset = 1'b1;
        exp_q.delete();
        exp_row = 0;
        pend_l1 = '0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.enable_in = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.data_skewed = '0;
        cycle(0, 0, '0, '0, 0);
        cycle(1, 0, '0, '0, 0);
        reset = 1'b1;
        exp_q.delete();
        exp_row = 0;
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, required 0", bus.out_valid); end
        checks++;
        if (bus.out_last !== 1'b0) begin errors++; $display("FAIL reset_last: got %b, required 0", bus.out_last); end
        checks++;
        if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b, required 0", bus.overflow); end
        checks++;
        if (bus.data !== '0) begin errors++; $display("FAIL reset_data: got %h, required 0", bus.data); end
    endtask

    task automatic test_single();
        row_t r = {32'hB, 32'hA};
        do_reset();
        cycle(1, 1, 32'hA, 32'hB, 1);
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL single_no_bypass: got %b, required 0", bus.out_valid); end
        cycle(1, 0, '0, '0, 1);
        checks++;
        if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b, required 1", bus.out_valid); end
        checks++;
        if (bus.data !== r) begin errors++; $display("FAIL single_data: got %h, required %h", bus.data, r); end
        checks++;
        if (bus.out_last !== 1'b0) begin errors++; $display("FAIL single_last: got %b, required 0", bus.out_last); end
        cycle(1, 0, '0, '0, 1);
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL single_after: got %b, required 0", bus.out_valid); end
    endtask

    task automatic test_back_to_back();
        row_t r1 = {32'd2, 32'd1};
        row_t r2 = {32'd4, 32'd3};
        do_reset();
        cycle(1, 1, 32'd1, 32'd2, 1);
        cycle(1, 1, 32'd3, 32'd4, 1);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.data !== r1 || bus.out_last !== 1'b0) begin
            errors++; $display("FAIL b2b_row0: got v=%b d=%h l=%b, required v=1 d=%h l=0", bus.out_valid, bus.data, bus.out_last, r1);
        end
        cycle(1, 1, 32'd5, 32'd6, 1);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.data !== r2 || bus.out_last !== 1'b1) begin
            errors++; $display("FAIL b2b_row1: got v=%b d=%h l=%b, required v=1 d=%h l=1", bus.out_valid, bus.data, bus.out_last, r2);
        end
        cycle(1, 0, '0, '0, 1);
        checks++;
        if (bus.out_last !== 1'b0) begin errors++; $display("FAIL b2b_wrap: got last %b, required 0", bus.out_last); end
        for (int k = 0; k < 3; k++) cycle(1, 0, '0, '0, 1);
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_drain: got %0d pending, required 0", exp_q.size()); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int k = 1; k <= 6; k++) begin
            cycle(1, 1, 32'h1000 + k, 32'h2000 + k, 0);
            if (k == 5) begin
                checks++;
                if (bus.overflow !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b, required 0", bus.overflow); end
            end
            if (k == 6) begin
                checks++;
                if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b, required 1", bus.overflow); end
            end
        end
        exp_q.delete(5);
        exp_q.delete(4);
        cycle(1, 0, '0, '0, 0);
        for (int k = 0; k < 6; k++) cycle(1, 0, '0, '0, 1);
        checks++;
        if (exp_q.size() != 0 || bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL ovf_drain: got %0d pending valid=%b, required 0 pending valid=0", exp_q.size(), bus.out_valid);
        end
        checks++;
        if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b, required 1", bus.overflow); end
        do_reset();
        checks++;
        if (bus.overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b, required 0", bus.overflow); end
    endtask

    task automatic test_enable_stall();
        row_t r = {32'h5A, 32'hA5};
        do_reset();
        cycle(1, 1, 32'hA5, 32'h5A, 1);
        for (int k = 0; k < 3; k++) cycle(0, 0, '0, '0, 1);
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL stall_early: got %b, required 0", bus.out_valid); end
        cycle(1, 0, '0, '0, 1);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.data !== r) begin
            errors++; $display("FAIL stall_row: got v=%b d=%h, required v=1 d=%h", bus.out_valid, bus.data, r);
        end
        cycle(1, 0, '0, '0, 1);
        cycle(1, 0, '0, '0, 1);
    endtask

    task automatic test_reset_mid();
        row_t r = {32'h42, 32'h41};
        do_reset();
        cycle(1, 1, 32'h11, 32'h12, 0);
        cycle(1, 1, 32'h21, 32'h22, 0);
        cycle(1, 1, 32'h31, 32'h32, 0);
        checks++;
        if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL rmid_buffered: got %b, required 1", bus.out_valid); end
        reset = 1'b0;
        cycle(1, 0, '0, '0, 0);
        reset = 1'b1;
        exp_q.delete();
        exp_row = 0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.overflow !== 1'b0 || bus.out_last !== 1'b0 || bus.data !== '0) begin
            errors++; $display("FAIL rmid_clear: got v=%b o=%b l=%b d=%h, required all 0", bus.out_valid, bus.overflow, bus.out_last, bus.data);
        end
        cycle(1, 1, 32'h41, 32'h42, 1);
        cycle(1, 0, '0, '0, 1);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.data !== r || bus.out_last !== 1'b0) begin
            errors++; $display("FAIL rmid_next: got v=%b d=%h l=%b, required v=1 d=%h l=0", bus.out_valid, bus.data, bus.out_last, r);
        end
        for (int k = 0; k < 4; k++) cycle(1, 0, '0, '0, 1);
        checks++;
        if (bus.out_valid !== 1'b0 || exp_q.size() != 0) begin
            errors++; $display("FAIL rmid_stale: got valid=%b pending=%0d, required 0 and 0", bus.out_valid, exp_q.size());
        end
    endtask

    task automatic test_full_pop_push();
        do_reset();
        for (int k = 1; k <= 5; k++) cycle(1, 1, 32'h3000 + k, 32'h4000 + k, 0);
        cycle(1, 1, 32'h3006, 32'h4006, 1);
        for (int k = 0; k < 8; k++) cycle(1, 0, '0, '0, 1);
        checks++;
        if (bus.overflow !== 1'b0) begin errors++; $display("FAIL fpp_overflow: got %b, required 0", bus.overflow); end
        checks++;
        if (exp_q.size() != 0 || bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL fpp_drain: got %0d pending valid=%b, required 0 pending valid=0", exp_q.size(), bus.out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_enable_stall();
        test_reset_mid();
        test_full_pop_push();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/output_deskewer.md
OUTPUT_DESKEWER -- requirements
Module: output_deskewer

Interface
REQ-001 Parameter MATRIX_SIZE, default 2: number of lanes; also rows per matrix.
REQ-002 Parameter DATA_SIZE, default 32: width of each lane element in bits.
REQ-003 Parameter FIFO_DEPTH, default 4: aligned-row buffer entries; power of two, minimum 2.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 enable_in  input  1  advances the deskew pipeline when high.
REQ-007 data_skewed  input  [DATA_SIZE-1:0] x MATRIX_SIZE  systolic-array edge outputs; lane i lags lane 0 by i cycles.
REQ-008 in_valid  input  1  qualifies the lane-0 element of a row in the same cycle.
REQ-009 data  output  [DATA_SIZE-1:0] x MATRIX_SIZE  realigned row, lane order preserved.
REQ-010 out_valid  output  1  data holds a row.
REQ-011 out_ready  input  1  consumer accepts the row; a pop occurs on out_valid and out_ready.
REQ-012 out_last  output  1  current row is the last row of a matrix.
REQ-013 overflow  output  1  sticky flag: an aligned row was dropped.

Function
REQ-014 Lane i SHALL be delayed by MATRIX_SIZE-1-i registers; lane MATRIX_SIZE-1 is not delayed.
REQ-015 in_valid SHALL pass through MATRIX_SIZE-1 registers, so valid aligns with the completed row.
REQ-016 When enable_in is low, all delay registers and the valid pipeline SHALL hold, and no FIFO write occurs.
REQ-017 An aligned valid row SHALL be written to the FIFO in cycle t+MATRIX_SIZE-1, where t is the cycle its in_valid was sampled, provided enable_in was high in every intervening cycle.
REQ-018 With the FIFO empty, out_valid SHALL rise in cycle t+MATRIX_SIZE; there is no combinational bypass.
REQ-019 data and out_valid SHALL come from registers; data SHALL hold while out_valid is high and out_ready is low.
REQ-020 A write into a full FIFO SHALL be accepted if a pop occurs in the same cycle.
REQ-021 A write into a full FIFO with no pop SHALL drop the row and set overflow; the FIFO contents are unchanged.
REQ-022 Simultaneous write and pop on a FIFO holding one entry SHALL keep out_valid high and present the new row next cycle.
REQ-023 FIFO pointers SHALL wrap modulo FIFO_DEPTH; the occupancy counter SHALL be clog2(FIFO_DEPTH)+1 bits wide.
REQ-024 The row counter (clog2(MATRIX_SIZE) bits, minimum 1) SHALL increment on each pop and wrap to 0 after the pop at MATRIX_SIZE-1.
REQ-025 out_last SHALL equal out_valid AND (row counter == MATRIX_SIZE-1).
REQ-026 overflow SHALL remain set until reset.

Reset
REQ-027 While reset is low at a clock edge, the module SHALL clear every delay register, valid-pipeline bit, FIFO pointer, occupancy, row counter and the overflow flag.
REQ-028 The cycle after reset, out_valid, out_last and overflow SHALL be 0 and data SHALL be all zeros.
REQ-029 A reset asserted mid-operation SHALL discard all in-flight and buffered rows; no stale row may appear after reset releases.

Structure
REQ-030 The shared package systolic_pkg SHALL hold the default MATRIX_SIZE and DATA_SIZE and a row typedef (array of MATRIX_SIZE DATA_SIZE-bit words).
REQ-031 The FIFO SHALL be a separate sub-module, deskew_fifo (parameters WIDTH and DEPTH; ports for push, pop, full, empty and registered output).
REQ-032 The delay lines SHALL be generated per lane using the codebase's existing shift-register primitive, with DEPTH MATRIX_SIZE-1-i and a direct wire for depth 0.

Verification
REQ-033 Scenario, MATRIX_SIZE=2, out_ready=1: send lane0=0xA at cycle 0 and lane1=0xB at cycle 1 -> data={0xA,0xB} with out_valid at cycle 2, out_last=0.
REQ-034 Scenario: two back-to-back skewed rows {1,2} then {3,4} -> out_valid high in cycles 2 and 3; out_last=1 on {3,4}; row counter returns to 0.
REQ-035 Scenario: out_ready=0, six consecutive rows, FIFO_DEPTH=4 -> rows 1-4 buffered, overflow=1 after row 5, then out_ready=1 drains rows 1-4 in order.
REQ-036 Scenario: enable_in low for 3 cycles between the lane-0 and lane-1 samples -> row still aligned, out_valid delayed by 3 cycles.
REQ-037 Scenario: reset low for 1 cycle while 2 rows are buffered -> next cycle out_valid=0, overflow=0, data=0; a following row emerges correctly with out_last=0.
REQ-038 Scenario: FIFO full and out_ready=1 with a write in the same cycle -> no drop, overflow stays 0, order preserved.
